// File: rtl/vga_frame_sequencer.sv
// Frame-rate sequencer: applies scroll/mode/speed changes only at vertical blanking start.
// Optional VGA_SEQ_AUTO_CYCLE_EN steps the mode every 2**AUTO_SHIFT frames.
module vga_frame_sequencer #(
    parameter int V_DISPLAY = 480,
    parameter int SCROLL_W  = 10,
    parameter int SPEED_RST = 1
`ifdef VGA_SEQ_AUTO_CYCLE_EN
    ,
    parameter int AUTO_SHIFT = 6
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [9:0]          hpos,
    input  logic [9:0]          vpos,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [1:0]          cfg_mode,
    input  logic [3:0]          cfg_speed,
    input  logic                pause,
    output logic                frame_start,
    output logic [SCROLL_W-1:0] scroll_x,
    output logic [1:0]          mode,
    output logic [3:0]          speed,
    output logic [7:0]          frame_cnt
);

    typedef enum logic {ACTIVE, UPDATE} state_t;

    state_t      state;
    logic        pending;
    logic [1:0]  shadow_mode;
    logic [3:0]  shadow_speed;
    logic        vb_hit;
    logic        accept;
    logic [3:0]  step;
    logic [7:0]  frame_next;

    assign vb_hit     = (hpos == 10'd0) && (vpos == 10'(V_DISPLAY));
    assign accept     = cfg_valid && cfg_ready;
    // A config applied in this UPDATE already drives this frame's scroll step
    assign step       = pending ? shadow_speed : speed;
    assign frame_next = frame_cnt + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ACTIVE;
            pending      <= 1'b0;
            shadow_mode  <= 2'd0;
            shadow_speed <= 4'd0;
            cfg_ready    <= 1'b1;
            frame_start  <= 1'b0;
            scroll_x     <= '0;
            mode         <= 2'd0;
            speed        <= 4'(SPEED_RST);
            frame_cnt    <= 8'd0;
        end else begin
            case (state)
                ACTIVE: begin
                    if (accept) begin
                        shadow_mode  <= cfg_mode;
                        shadow_speed <= cfg_speed;
                        pending      <= 1'b1;
                    end
                    // ready is held low through UPDATE so nothing can race the apply
                    if (vb_hit) begin
                        state       <= UPDATE;
                        frame_start <= 1'b1;
                        cfg_ready   <= 1'b0;
                    end else begin
                        cfg_ready   <= !(pending || accept);
                    end
                end
                UPDATE: begin
                    state       <= ACTIVE;
                    frame_start <= 1'b0;
                    pending     <= 1'b0;
                    cfg_ready   <= 1'b1;
                    if (pending) begin
                        speed <= shadow_speed;
                    end
`ifdef VGA_SEQ_AUTO_CYCLE_EN
                    if (pending) begin
                        mode <= shadow_mode;
                    end else if (frame_next[AUTO_SHIFT-1:0] == '0) begin
                        mode <= mode + 2'd1;
                    end
`else
                    if (pending) begin
                        mode <= shadow_mode;
                    end
`endif
                    if (!pause) begin
                        scroll_x <= scroll_x + {{(SCROLL_W-4){1'b0}}, step};
                    end
                    frame_cnt <= frame_next;
                end
                default: state <= ACTIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Self-checking bench for vga_frame_sequencer: directed scenarios with literal pins,
// then randomized config/pause traffic compared every cycle against a queue-based model.
module tb_vga_frame_sequencer;

    localparam int V_DISPLAY  = 480;
    localparam int H_COLS     = 12;
    localparam int N_LINES    = 9;
    localparam int FRAME_CYC  = H_COLS * N_LINES;
    localparam int AUTO_SHIFT = 6;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic [9:0] hpos      = 10'd0;
    logic [9:0] vpos      = 10'd0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_mode  = 2'd0;
    logic [3:0] cfg_speed = 4'd0;
    logic       pause     = 1'b0;
    logic       cfg_ready;
    logic       frame_start;
    logic [9:0] scroll_x;
    logic [1:0] mode;
    logic [3:0] speed;
    logic [7:0] frame_cnt;

    int checks     = 0;
    int failures   = 0;
    int pulses     = 0;
    int raster_idx = 0;
    bit rand_en    = 1'b0;

    // Reference model: pending words in a queue, an UPDATE flag, and plain arithmetic
    typedef struct packed {
        logic [1:0] md;
        logic [3:0] sp;
    } cfg_t;

    cfg_t       m_q[$];
    bit         m_upd     = 1'b0;
    bit         m_fs      = 1'b0;
    bit         m_applied = 1'b0;
    logic [9:0] m_scroll  = 10'd0;
    logic [1:0] m_mode    = 2'd0;
    logic [3:0] m_speed   = 4'd1;
    logic [7:0] m_cnt     = 8'd0;

    vga_frame_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .hpos        (hpos),
        .vpos        (vpos),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_mode    (cfg_mode),
        .cfg_speed   (cfg_speed),
        .pause       (pause),
        .frame_start (frame_start),
        .scroll_x    (scroll_x),
        .mode        (mode),
        .speed       (speed),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d t=%0t", name, actual, required, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_upd    = 1'b0;
            m_fs     = 1'b0;
            m_scroll = 10'd0;
            m_mode   = 2'd0;
            m_speed  = 4'd1;
            m_cnt    = 8'd0;
        end else if (m_upd) begin
            m_applied = 1'b0;
            if (m_q.size() > 0) begin
                m_mode    = m_q[0].md;
                m_speed   = m_q[0].sp;
                m_applied = 1'b1;
                m_q.pop_front();
            end
            if (!pause) m_scroll = m_scroll + 10'(m_speed);
            m_cnt = m_cnt + 8'd1;
`ifdef VGA_SEQ_AUTO_CYCLE_EN
            if (!m_applied && (int'(m_cnt) % (1 << AUTO_SHIFT) == 0)) m_mode = m_mode + 2'd1;
`endif
            m_upd = 1'b0;
            m_fs  = 1'b0;
        end else begin
            if (cfg_valid && m_q.size() == 0) m_q.push_back(cfg_t'({cfg_mode, cfg_speed}));
            if (hpos == 10'd0 && vpos == 10'(V_DISPLAY)) begin
                m_upd = 1'b1;
                m_fs  = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (frame_start === 1'b1) pulses++;
        check_output("frame_start", int'(frame_start), int'(m_fs));
        check_output("cfg_ready", int'(cfg_ready), int'(m_q.size() == 0 && !m_upd));
        check_output("scroll_x", int'(scroll_x), int'(m_scroll));
        check_output("mode", int'(mode), int'(m_mode));
        check_output("speed", int'(speed), int'(m_speed));
        check_output("frame_cnt", int'(frame_cnt), int'(m_cnt));
    end

    task automatic set_raster();
        int h;
        int l;
        h = raster_idx % H_COLS;
        l = raster_idx / H_COLS;
        hpos = 10'(h);
        vpos = (l == 0) ? 10'd0 : 10'(V_DISPLAY - 4 + l);
    endtask

    task automatic apply_stimulus();
        bit take;
        @(negedge clk);
        take = cfg_valid && cfg_ready;
        @(posedge clk);
        #1;
        if (take) begin
            cfg_valid = 1'b0;
        end else if (rand_en && cfg_valid && $urandom_range(0, 19) == 0) begin
            cfg_valid = 1'b0;
        end
        if (rand_en && !cfg_valid && $urandom_range(0, 29) == 0) begin
            cfg_valid = 1'b1;
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_speed = 4'($urandom_range(0, 15));
        end
        if (rand_en) pause = ($urandom_range(0, 3) == 0);
        raster_idx = (raster_idx + 1) % FRAME_CYC;
        set_raster();
    endtask

    task automatic run_frames(input int n);
        repeat (n * FRAME_CYC) apply_stimulus();
    endtask

    task automatic offer(input logic [1:0] m, input logic [3:0] s);
        cfg_valid = 1'b1;
        cfg_mode  = m;
        cfg_speed = s;
        apply_stimulus();
    endtask

    task automatic check_all(input string tag, input int sx, input int md, input int sp, input int fc, input int rdy);
        check_output({tag, "_scroll"}, int'(scroll_x), sx);
        check_output({tag, "_mode"}, int'(mode), md);
        check_output({tag, "_speed"}, int'(speed), sp);
        check_output({tag, "_cnt"}, int'(frame_cnt), fc);
        check_output({tag, "_ready"}, int'(cfg_ready), rdy);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        set_raster();
        #3;
        check_all("reset", 0, 0, 1, 0, 1);
        check_output("reset_fs", int'(frame_start), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Free-run three frames at the reset speed
        run_frames(3);
        check_output("free_pulses", pulses, 3);
        check_all("free", 3, 0, 1, 3, 1);

        // Mid-frame handshake, applied at the next boundary with the new step
        offer(2'd2, 4'd5);
        check_all("hs_pending", 3, 0, 1, 3, 0);
        run_frames(1);
        check_all("hs_applied", 8, 2, 5, 4, 1);

        // Back-pressure: second word waits until the cycle after UPDATE
        offer(2'd1, 4'd3);
        cfg_valid = 1'b1;
        cfg_mode  = 2'd3;
        cfg_speed = 4'd7;
        repeat (5) apply_stimulus();
        check_all("bp_stall", 8, 2, 5, 4, 0);
        run_frames(1);
        check_all("bp_first", 11, 1, 3, 5, 0);
        run_frames(1);
        check_all("bp_second", 18, 3, 7, 6, 1);

        // Climb to 1020 then wrap with speed 8; pause holds scroll but not frame_cnt
        offer(2'd0, 4'd15);
        run_frames(66);
        offer(2'd0, 4'd12);
        run_frames(1);
        check_output("wrap_pre_scroll", int'(scroll_x), 1020);
        offer(2'd0, 4'd8);
        run_frames(1);
        check_output("wrap_scroll", int'(scroll_x), 4);
        check_output("wrap_cnt", int'(frame_cnt), 74);
        pause = 1'b1;
        run_frames(2);
        pause = 1'b0;
        check_output("pause_scroll", int'(scroll_x), 4);
        check_output("pause_cnt", int'(frame_cnt), 76);

        // Async reset in the middle of UPDATE with a word pending
        offer(2'd2, 4'd9);
        for (int i = 0; i < 2 * FRAME_CYC && !m_upd; i++) apply_stimulus();
        check_output("reach_update_fs", int'(frame_start), 1);
        reset = 1'b1;
        #1;
        check_all("async_reset", 0, 0, 1, 0, 1);
        check_output("async_reset_fs", int'(frame_start), 0);
        apply_stimulus();
        reset = 1'b0;
        run_frames(1);
        check_all("post_reset", 1, 0, 1, 1, 1);

        // Randomized config traffic, withdrawals and pause against the model
        rand_en = 1'b1;
        run_frames(40);
        rand_en   = 1'b0;
        cfg_valid = 1'b0;
        pause     = 1'b0;
        run_frames(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_frame_sequencer.md
Name: vga_frame_sequencer

Overview:
- Frame-rate controller for the VGA pattern datapath.
- Tracks the beam position from the sync generator and detects the start of vertical blanking.
- At each blanking start it advances the horizontal scroll offset and applies pending pattern configuration, so the datapath never changes mid-frame.
- Configuration arrives over a valid/ready handshake from the top level (ui_in decode) and is held in a one-entry shadow register until the next frame boundary.

Parameters:
- V_DISPLAY, 480, first non-visible line; blanking-start detect line.
- SCROLL_W, 10, width of the scroll accumulator.
- SPEED_RST, 1, speed value loaded at reset.
- AUTO_SHIFT, 6, log2 of frames between automatic mode steps (optional feature only).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- hpos  in  10  current beam column from the sync generator.
- vpos  in  10  current beam line from the sync generator.
- cfg_valid  in  1  config word offered.
- cfg_ready  out  1  shadow register free; a transfer occurs when cfg_valid and cfg_ready are both high at a clk edge.
- cfg_mode  in  2  requested pattern mode.
- cfg_speed  in  4  requested scroll step per frame.
- pause  in  1  freezes scroll advance while high.
- frame_start  out  1  one-cycle pulse at blanking start.
- scroll_x  out  SCROLL_W  offset added to hpos by the datapath.
- mode  out  2  active pattern mode.
- speed  out  4  active scroll step.
- frame_cnt  out  8  frames since reset, wraps 255->0.

Behaviour:
- Clock and reset: single clock domain. reset asserts asynchronously and clears all state immediately, including mid-handshake or mid-UPDATE.
- Reset values: scroll_x=0, mode=0, speed=SPEED_RST, frame_cnt=0, frame_start=0, cfg_ready=1, pending=0, state=ACTIVE.
- Blanking detect: vb_hit = (hpos==0 && vpos==V_DISPLAY), combinational. It is true for exactly one cycle per frame.
- FSM states:
  - ACTIVE: if vb_hit, go to UPDATE at the next edge and register frame_start=1 at the same edge.
  - UPDATE: lasts one cycle; frame_start=0 at its exit edge. At the exit edge:
    - if pending: mode<=shadow_mode, speed<=shadow_speed, pending<=0, cfg_ready<=1.
    - if !pause: scroll_x <= scroll_x + zero-extended step, modulo 2^SCROLL_W. The step is the newly applied speed if a config was applied at this edge, otherwise the current speed.
    - frame_cnt <= frame_cnt+1, regardless of pause.
    - return to ACTIVE.
- Latency: a config accepted at edge T becomes visible on mode/speed at the UPDATE exit edge, which is 2 edges after the vb_hit cycle of the first frame boundary following T.
- Handshake:
  - cfg_ready is a register: 1 when pending=0 and state is not UPDATE.
  - On acceptance: shadow <= cfg inputs, pending<=1, cfg_ready<=0 at that edge.
  - cfg_ready is forced 0 throughout UPDATE, so no acceptance can race the apply.
  - A second word offered while pending stays stalled (cfg_ready=0). It is accepted the cycle after UPDATE and applied at the following frame.
- Boundaries:
  - speed=0: scroll holds.
  - scroll 1020+8 -> 4 (wrap).
  - pause asserted during the vb_hit cycle: pause is sampled in UPDATE; only that sampled value matters.
  - cfg_valid dropped before ready: no transfer, no state change.
- vb_hit while in UPDATE cannot occur. If the inputs are inconsistent, hits are ignored outside ACTIVE.

Optional Feature:
- Macro: VGA_SEQ_AUTO_CYCLE_EN.
- Defined: in UPDATE, when pending=0 and the post-increment frame_cnt[AUTO_SHIFT-1:0]==0, mode <= mode+1 (wraps 3->0). A pending config applied in the same UPDATE takes priority and suppresses that step.
- Undefined: mode changes only through the handshake. No extra logic is synthesized.

Test Plan:
- Reset then free-run 3 frames (hpos/vpos sweep 0..799 / 0..524), speed=1 -> frame_start pulses exactly 3 times, each 1 cycle wide, one edge after hpos=0,vpos=480; scroll_x 0->1->2->3; frame_cnt=3.
- Handshake: accept mode=2, speed=5 mid-frame -> cfg_ready drops next edge; mode/speed unchanged until UPDATE exit; then mode=2, speed=5, scroll_x += 5, cfg_ready=1.
- Back-pressure: hold cfg_valid with a second word (mode=3) while pending -> no acceptance; accepted the cycle after UPDATE; mode=3 appears one frame later.
- Wrap and pause: preload scroll_x=1020, speed=8 -> 4 after one frame; pause=1 for 2 frames -> scroll_x holds at 4, frame_cnt still +2.
- Async reset asserted during UPDATE with pending=1 -> all outputs return to reset values without a clk edge; shadow discarded; cfg_ready=1.
- With VGA_SEQ_AUTO_CYCLE_EN, AUTO_SHIFT=2, no config -> mode steps 0->1->2->3->0 at frame_cnt 4, 8, 12, 16; a config applied at frame 8 overrides that step.
